// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad sequence-entry block.
//   state_t        : scanner FSM states (SCAN, DEBOUNCE, HOLD)
//   ROWS / COLS    : keypad matrix size
//   ROW_IDLE       : row pattern with no key pressed (all pulled up)
//   lowest_low_row : index of the lowest-numbered active-low row
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam logic [ROWS-1:0] ROW_IDLE = 4'hF;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } state_t;

  // Several rows low at once resolve to the lowest-numbered one.
  function automatic logic [1:0] lowest_low_row(input logic [ROWS-1:0] r);
    logic [1:0] idx;
    if (!r[0]) begin
      idx = 2'd0;
    end else if (!r[1]) begin
      idx = 2'd1;
    end else if (!r[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_seq_entry_if.sv
// keypad_seq_entry_if: key/sequence bus between the keypad scanner and its
// consumer (e.g. a display marquee).
//   clr       : synchronous clear of seq and digit_cnt (consumer -> scanner)
//   key_valid : one-cycle pulse per accepted key
//   key_code  : code of the last accepted key (row*4 + col)
//   seq       : assembled digit sequence, newest digit in the low nibble
//   digit_cnt : digits entered, saturating at N/WIDTH
// Modports: master = scanner side, slave = consumer side.
interface keypad_seq_entry_if #(
  parameter int N     = 32,
  parameter int WIDTH = 4
);
  logic                      clr;
  logic                      key_valid;
  logic [3:0]                key_code;
  logic [N-1:0]              seq;
  logic [$clog2(N/WIDTH):0]  digit_cnt;

  modport master (input clr, output key_valid, key_code, seq, digit_cnt);
  modport slave  (output clr, input key_valid, key_code, seq, digit_cnt);
endinterface

// File: rtl/keypad_col_scan.sv
// keypad_col_scan: column strobe generator for a 4x4 keypad.
//   clk, rst_n : clock, asynchronous active-low reset
//   freeze     : hold the column index at the current dwell end
//   col        : active-low column strobe, exactly one bit low
//   col_idx    : index of the strobed column
//   dwell_end  : high on the last cycle of each SCAN_DIV-cycle dwell
// The dwell timer always runs so that dwell-end samples keep coming while
// the index is frozen.
module keypad_col_scan #(
  parameter int SCAN_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       freeze,
  output logic [3:0] col,
  output logic [1:0] col_idx,
  output logic       dwell_end
);
  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] LAST = TW'(SCAN_DIV - 1);

  logic [TW-1:0] timer_r;
  logic [1:0]    idx_r;
  logic [3:0]    col_r;
  logic [1:0]    idx_next_s;

  assign idx_next_s = idx_r + 2'd1;
  assign dwell_end  = (timer_r == LAST);
  assign col        = col_r;
  assign col_idx    = idx_r;

  // Dwell timer plus column index; the strobe is registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= '0;
      idx_r   <= 2'd0;
      col_r   <= 4'b1110;
    end else begin
      if (dwell_end) begin
        timer_r <= '0;
      end else begin
        timer_r <= timer_r + TW'(1);
      end
      if (dwell_end && !freeze) begin
        idx_r <= idx_next_s;
        col_r <= ~(4'b0001 << idx_next_s);
      end
    end
  end

endmodule

// File: rtl/keypad_seq_entry.sv
// keypad_seq_entry: 4x4 keypad scanner with debounce that assembles
// accepted key codes into an N-bit hex sequence.
//   sys_clk   : clock
//   sys_rst_n : asynchronous active-low reset
//   row       : keypad rows, active-low, pulled up
//   col       : column strobe, active-low
//   kbus      : keypad_seq_entry_if master (clr in; key_valid, key_code,
//               seq, digit_cnt out)
// Build option: define KEYPAD_ROW_SYNC_EN to pass row through a two-flop
// synchronizer and delay the key outputs by two cycles to match.
module keypad_seq_entry #(
  parameter int N        = 32,
  parameter int WIDTH    = 4,
  parameter int SCAN_DIV = 50_000,
  parameter int DEBOUNCE = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  keypad_seq_entry_if.master kbus
);
  import keypad_pkg::*;

  localparam int DIGITS = N / WIDTH;
  localparam int CW     = $clog2(DIGITS) + 1;
  localparam int CNT_W  = $clog2(DEBOUNCE + 1);

  logic [3:0]       row_s;
  logic             dwell_end_s;
  logic             freeze_s;
  logic [1:0]       col_idx_s;

  state_t           state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r, next_cnt_s;
  logic [1:0]       cand_col_r, cand_row_r;
  logic [3:0]       cand_pat_r;
  logic             latch_s, accept_s;
  logic [3:0]       code_s;
  logic             out_accept_s;
  logic [3:0]       out_code_s;

  logic             key_valid_r;
  logic [3:0]       key_code_r;
  logic [N-1:0]     seq_r;
  logic [CW-1:0]    digit_cnt_r;

  keypad_col_scan #(.SCAN_DIV(SCAN_DIV)) u_col_scan (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .freeze    (freeze_s),
    .col       (col),
    .col_idx   (col_idx_s),
    .dwell_end (dwell_end_s)
  );

`ifdef KEYPAD_ROW_SYNC_EN
  logic [3:0] row_meta_r, row_sync_r;
  logic       accept_p1_r, accept_p2_r;
  logic [3:0] code_p1_r, code_p2_r;

  // Two-flop row synchronizer; idle level on reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      row_meta_r <= ROW_IDLE;
      row_sync_r <= ROW_IDLE;
    end else begin
      row_meta_r <= row;
      row_sync_r <= row_meta_r;
    end
  end

  // Two-stage delay of the accept event to match the synchronizer latency.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      accept_p1_r <= 1'b0;
      accept_p2_r <= 1'b0;
      code_p1_r   <= 4'h0;
      code_p2_r   <= 4'h0;
    end else begin
      accept_p1_r <= accept_s;
      accept_p2_r <= accept_p1_r;
      code_p1_r   <= code_s;
      code_p2_r   <= code_p1_r;
    end
  end

  assign row_s        = row_sync_r;
  assign out_accept_s = accept_p2_r;
  assign out_code_s   = code_p2_r;
`else
  assign row_s        = row;
  assign out_accept_s = accept_s;
  assign out_code_s   = code_s;
`endif

  assign code_s = {cand_row_r, cand_col_r};
  // Index advances at a dwell end only when the FSM is (staying/returning) in SCAN.
  assign freeze_s = (next_state_s != keypad_pkg::SCAN);

  // FSM next state; decisions are taken only on dwell-end samples.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    latch_s      = 1'b0;
    accept_s     = 1'b0;
    if (dwell_end_s) begin
      case (state_r)
        keypad_pkg::SCAN: begin
          if (row_s != ROW_IDLE) begin
            latch_s      = 1'b1;
            next_cnt_s   = CNT_W'(1);
            next_state_s = keypad_pkg::DEBOUNCE;
          end else begin
            next_state_s = keypad_pkg::SCAN;
          end
        end
        keypad_pkg::DEBOUNCE: begin
          if (row_s == cand_pat_r) begin
            if (cnt_r == CNT_W'(DEBOUNCE - 1)) begin
              accept_s     = 1'b1;
              next_cnt_s   = '0;
              next_state_s = keypad_pkg::HOLD;
            end else begin
              next_cnt_s = cnt_r + CNT_W'(1);
            end
          end else begin
            next_cnt_s   = '0;
            next_state_s = keypad_pkg::SCAN;
          end
        end
        keypad_pkg::HOLD: begin
          if (row_s == ROW_IDLE) begin
            if (cnt_r == CNT_W'(DEBOUNCE - 1)) begin
              next_cnt_s   = '0;
              next_state_s = keypad_pkg::SCAN;
            end else begin
              next_cnt_s = cnt_r + CNT_W'(1);
            end
          end else begin
            next_cnt_s = '0;
          end
        end
        default: begin
          next_cnt_s   = '0;
          next_state_s = keypad_pkg::SCAN;
        end
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // FSM state, stable count and candidate key registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r    <= keypad_pkg::SCAN;
      cnt_r      <= '0;
      cand_col_r <= 2'd0;
      cand_row_r <= 2'd0;
      cand_pat_r <= ROW_IDLE;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
      if (latch_s) begin
        cand_col_r <= col_idx_s;
        cand_row_r <= lowest_low_row(row_s);
        cand_pat_r <= row_s;
      end
    end
  end

  // Key outputs and sequence assembly; clr overrides seq/digit_cnt only.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_valid_r <= 1'b0;
      key_code_r  <= 4'h0;
      seq_r       <= '0;
      digit_cnt_r <= '0;
    end else begin
      key_valid_r <= out_accept_s;
      if (out_accept_s) begin
        key_code_r <= out_code_s;
      end
      if (kbus.clr) begin
        seq_r       <= '0;
        digit_cnt_r <= '0;
      end else if (out_accept_s) begin
        seq_r <= {seq_r[N-WIDTH-1:0], WIDTH'(out_code_s)};
        if (digit_cnt_r != CW'(DIGITS)) begin
          digit_cnt_r <= digit_cnt_r + CW'(1);
        end
      end
    end
  end

  assign kbus.key_valid = key_valid_r;
  assign kbus.key_code  = key_code_r;
  assign kbus.seq       = seq_r;
  assign kbus.digit_cnt = digit_cnt_r;

endmodule

// File: tb/tb_keypad_seq_entry.sv
// tb_keypad_seq_entry: self-checking bench for keypad_seq_entry with
// SCAN_DIV=4, DEBOUNCE=3, N=32. A keypad model drives row low only while
// the pressed key's column is strobed; a scoreboard queue holds expected
// (code, seq, digit_cnt) per key, popped on every key_valid pulse.
module tb_keypad_seq_entry;
  localparam int N        = 32;
  localparam int WIDTH    = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  typedef struct packed {
    logic [3:0]   code;
    logic [N-1:0] seq;
    logic [3:0]   cnt;
  } exp_t;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;

  logic       key_down = 1'b0;
  logic [1:0] key_c    = 2'd0;
  logic [3:0] key_mask = 4'h0;

  int         total = 0;
  int         bad   = 0;
  exp_t       exp_q[$];
  logic [N-1:0] seq_m = '0;
  logic [3:0]   cnt_m = 4'd0;

  keypad_seq_entry_if #(.N(N), .WIDTH(WIDTH)) kbus ();

  keypad_seq_entry #(
    .N(N), .WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .row       (row),
    .col       (col),
    .kbus      (kbus.master)
  );

  always #5 sys_clk = ~sys_clk;

  // Keypad matrix model: the pressed key only pulls rows while its column is low.
  always_comb begin
    if (key_down && (col[key_c] == 1'b0)) row = ~key_mask;
    else                                  row = 4'hF;
  end

  task automatic push_expect(input logic [3:0] code);
    exp_t e;
    seq_m = {seq_m[N-5:0], code};
    if (cnt_m != 4'd8) cnt_m = cnt_m + 4'd1;
    e.code = code; e.seq = seq_m; e.cnt = cnt_m;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && kbus.key_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_key_valid: got code=%h seq=%h cnt=%0d, required no pulse",
                   kbus.key_code, kbus.seq, kbus.digit_cnt);
        end else begin
          e = exp_q.pop_front();
          if ({kbus.key_code, kbus.seq, kbus.digit_cnt} !== {e.code, e.seq, e.cnt}) begin
            bad++;
            $display("FAIL key_accept: got code=%h seq=%h cnt=%0d, required code=%h seq=%h cnt=%0d",
                     kbus.key_code, kbus.seq, kbus.digit_cnt, e.code, e.seq, e.cnt);
          end
        end
      end
    end
  endtask

  task automatic wait_col_entry(input logic [3:0] target);
    int n;
    n = 0;
    while (col == target && n < 100) begin @(negedge sys_clk); n++; end
    while (col != target && n < 100) begin @(negedge sys_clk); n++; end
    total++;
    if (col !== target) begin
      bad++;
      $display("FAIL col_entry_timeout: got col=%b, required %b", col, target);
    end
  endtask

  task automatic press_key(input logic [1:0] c, input logic [3:0] mask,
                           input logic [3:0] code, input int hold);
    int n;
    push_expect(code);
    key_c = c; key_mask = mask; key_down = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge sys_clk); n++; end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL press_timeout: code=%h pending=%0d, required 0", code, exp_q.size());
      exp_q.delete();
    end
    repeat (hold) @(negedge sys_clk);
    key_down = 1'b0;
    repeat (5 * SCAN_DIV) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0; key_down = 1'b0; kbus.clr = 1'b0;
    exp_q.delete(); seq_m = '0; cnt_m = 4'd0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    total += 5;
    if (col !== 4'b1110)          begin bad++; $display("FAIL reset_col: got %b required 1110", col); end
    if (kbus.key_valid !== 1'b0)  begin bad++; $display("FAIL reset_key_valid: got %b required 0", kbus.key_valid); end
    if (kbus.key_code !== 4'h0)   begin bad++; $display("FAIL reset_key_code: got %h required 0", kbus.key_code); end
    if (kbus.seq !== 32'h0)       begin bad++; $display("FAIL reset_seq: got %h required 0", kbus.seq); end
    if (kbus.digit_cnt !== 4'd0)  begin bad++; $display("FAIL reset_digit_cnt: got %0d required 0", kbus.digit_cnt); end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  // Called right after reset release on a falling edge: timer=0, index=0.
  task automatic test_scan();
    logic [3:0] one;
    logic [3:0] exp_col;
    one = 4'b0001;
    for (int p = 0; p < 64; p++) begin
      exp_col = ~(one << ((p / SCAN_DIV) % 4));
      total++;
      if (col !== exp_col) begin
        bad++;
        $display("FAIL scan_col[%0d]: got %b required %b", p, col, exp_col);
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic test_single_key();
    press_key(2'd2, 4'b0010, 4'h6, 100);
    total += 3;
    if (kbus.key_code !== 4'h6)        begin bad++; $display("FAIL single_code: got %h required 6", kbus.key_code); end
    if (kbus.seq !== 32'h0000_0006)    begin bad++; $display("FAIL single_seq: got %h required 00000006", kbus.seq); end
    if (kbus.digit_cnt !== 4'd1)       begin bad++; $display("FAIL single_cnt: got %0d required 1", kbus.digit_cnt); end
  endtask

  task automatic test_multi_row();
    // Rows 1 and 3 low on column 3: lowest row wins -> code 7.
    press_key(2'd3, 4'b1010, 4'h7, 8);
    total++;
    if (kbus.seq !== 32'h0000_0067) begin bad++; $display("FAIL multi_row_seq: got %h required 00000067", kbus.seq); end
  endtask

  task automatic test_sequence();
    logic [3:0] m;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      m = 4'b0001 << (k / 4);
      press_key(2'(k % 4), m, 4'(k), 8);
    end
    total += 2;
    if (kbus.seq !== 32'h2345_6789) begin bad++; $display("FAIL seq_nine: got %h required 23456789", kbus.seq); end
    if (kbus.digit_cnt !== 4'd8)    begin bad++; $display("FAIL seq_cnt_sat: got %0d required 8", kbus.digit_cnt); end
  endtask

  task automatic test_bounce();
    key_c = 2'd1; key_mask = 4'b0001;
    wait_col_entry(4'b1101);
    key_down = 1'b1;
    repeat (10) @(negedge sys_clk);
    key_down = 1'b0;
    repeat (2) @(negedge sys_clk);
    total++;
    if (col !== 4'b1011) begin bad++; $display("FAIL bounce_resume_col: got %b required 1011", col); end
    repeat (4) @(negedge sys_clk);
    total++;
    if (col !== 4'b0111) begin bad++; $display("FAIL bounce_next_col: got %b required 0111", col); end
  endtask

  task automatic test_clr_accept();
    exp_t e;
    int   n;
    key_c = 2'd1; key_mask = 4'b0010;
    wait_col_entry(4'b1101);
    seq_m = '0; cnt_m = 4'd0;
    e.code = 4'h5; e.seq = '0; e.cnt = 4'd0;
    exp_q.push_back(e);
    key_down = 1'b1;
    repeat (11) @(negedge sys_clk);
    kbus.clr = 1'b1;
    @(negedge sys_clk);
    kbus.clr = 1'b0;
    total += 3;
    if (kbus.key_valid !== 1'b1) begin bad++; $display("FAIL clr_accept_valid: got %b required 1", kbus.key_valid); end
    if (kbus.seq !== 32'h0)      begin bad++; $display("FAIL clr_accept_seq: got %h required 0", kbus.seq); end
    if (kbus.digit_cnt !== 4'd0) begin bad++; $display("FAIL clr_accept_cnt: got %0d required 0", kbus.digit_cnt); end
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin @(negedge sys_clk); n++; end
    total++;
    if (kbus.key_code !== 4'h5) begin bad++; $display("FAIL clr_accept_code: got %h required 5", kbus.key_code); end
    key_down = 1'b0;
    repeat (5 * SCAN_DIV) @(negedge sys_clk);
    press_key(2'd2, 4'b0100, 4'hA, 8);
    total++;
    if (kbus.seq !== 32'h0000_000A) begin bad++; $display("FAIL after_clr_seq: got %h required 0000000a", kbus.seq); end
  endtask

  task automatic test_reset_mid();
    key_c = 2'd2; key_mask = 4'b1000;
    wait_col_entry(4'b1011);
    key_down = 1'b1;
    repeat (6) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    key_down  = 1'b0;
    exp_q.delete(); seq_m = '0; cnt_m = 4'd0;
    #1;
    total += 3;
    if (col !== 4'b1110)         begin bad++; $display("FAIL mid_reset_col: got %b required 1110", col); end
    if (kbus.seq !== 32'h0)      begin bad++; $display("FAIL mid_reset_seq: got %h required 0", kbus.seq); end
    if (kbus.digit_cnt !== 4'd0) begin bad++; $display("FAIL mid_reset_cnt: got %0d required 0", kbus.digit_cnt); end
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (40) @(negedge sys_clk);
  endtask

  initial begin
    kbus.clr = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_scan();
    test_single_key();
    test_multi_row();
    test_sequence();
    test_bounce();
    test_clr_accept();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_expect: got %0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_seq_entry.md
KEYPAD_SEQ_ENTRY -- requirements
Module: keypad_seq_entry

Interface
REQ-001 SHALL have parameter N, default 32, meaning the width of the assembled hex sequence in bits.
REQ-002 SHALL have parameter WIDTH, default 4, meaning the bits per digit (N/WIDTH digits).
REQ-003 SHALL have parameter SCAN_DIV, default 50_000, meaning the sys_clk cycles each column stays strobed (dwell).
REQ-004 SHALL have parameter DEBOUNCE, default 4, meaning the consecutive identical dwell-end samples needed to accept a press or release.
REQ-005 sys_clk  input  1  single clock; all state changes on its rising edge.
REQ-006 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-007 row  input  4  keypad rows, active-low, externally pulled up.
REQ-008 col  output  4  column strobe, active-low, exactly one bit low at all times.
REQ-009 clr  input  1  synchronous clear of seq and digit_cnt.
REQ-010 key_valid  output  1  one-cycle pulse per accepted key.
REQ-011 key_code  output  4  code of the last accepted key.
REQ-012 seq  output  N  assembled digit sequence; feeds the display marquee seq input.
REQ-013 digit_cnt  output  $clog2(N/WIDTH)+1  digits entered, saturating.

Function
REQ-014 Column index SHALL advance 0->1->2->3->0 every SCAN_DIV cycles in SCAN only; col = ~(4'b0001 << index).
REQ-015 Row SHALL be sampled only on the last cycle of each dwell ("dwell-end sample").
REQ-016 FSM states SCAN, DEBOUNCE, HOLD; in DEBOUNCE and HOLD the column index SHALL freeze.
REQ-017 SCAN: dwell-end sample != 4'hF -> latch candidate (index, lowest-numbered low row), stable count=1, go DEBOUNCE; else advance column.
REQ-018 DEBOUNCE: sample equals candidate pattern -> count++; count reaching DEBOUNCE -> accept, go HOLD; any mismatch -> SCAN, advance column.
REQ-019 Accept SHALL, in one cycle: key_valid=1, key_code=row_idx*4+col_idx, seq <= {seq[N-WIDTH-1:0], key_code zero-extended to WIDTH}, digit_cnt++ saturating at N/WIDTH.
REQ-020 HOLD: DEBOUNCE consecutive samples of 4'hF -> SCAN, advance column; any low row resets the release count; no repeat accepts while held.
REQ-021 Multiple rows low SHALL resolve to the lowest-numbered row; other columns are ignored while not strobed.
REQ-022 clr SHALL zero seq and digit_cnt next cycle; clr coincident with accept: clr wins for seq/digit_cnt, key_valid and key_code still update; FSM unaffected.
REQ-023 seq SHALL keep shifting after digit_cnt saturates (oldest digit discarded).

Reset
REQ-024 On sys_rst_n low, immediately: state=SCAN, index=0, col=4'b1110, dwell timer=0, counts=0, key_valid=0, key_code=0, seq=0, digit_cnt=0.
REQ-025 Reset mid-DEBOUNCE or mid-HOLD SHALL discard the candidate with no key_valid.

Configuration
REQ-026 Macro KEYPAD_ROW_SYNC_EN defined: row passes a two-flop synchronizer (reset to 4'hF) before sampling; key_valid delayed 2 cycles relative to undefined.
REQ-027 Macro undefined: row sampled directly; no synchronizer flops present.

Structure
REQ-028 Shared package keypad_pkg SHALL hold the state typedef (SCAN, DEBOUNCE, HOLD), ROWS=4, COLS=4, ROW_IDLE=4'hF.
REQ-029 One sub-module keypad_col_scan SHALL hold the dwell timer, column index and strobe decode, with a freeze input and a dwell_end pulse output.

Verification (SCAN_DIV=4, DEBOUNCE=3, N=32, macro undefined)
REQ-030 Reset, row=4'hF for 64 cycles -> col cycles 1110,1101,1011,0111 every 4 cycles; key_valid never asserts.
REQ-031 Hold row=4'b1101 while col=1011 -> one key_valid, key_code=4'h6, seq=32'h0000_0006, digit_cnt=1; held 100 cycles: no second pulse.
REQ-032 Enter 9 keys codes 1..9 with release -> seq=32'h2345_6789, digit_cnt=8.
REQ-033 Row low for 2 dwell samples then bounce high -> no key_valid; scan resumes at next column.
REQ-034 clr in the accept cycle -> key_valid=1, seq=0, digit_cnt=0 next cycle.
REQ-035 Reset asserted mid-DEBOUNCE -> col=4'b1110 and seq=0 immediately; no key_valid after release.
